mips_ctrl_fsm: RTL and testbench
================================

MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: the maximum number of cycles a memory state waits for MemReady before faulting.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Opcode, input, 6 bits: IR[31:26], stable from DECODE until the next FETCH.
REQ-005 SHALL have port Funct, input, 6 bits: IR[5:0].
REQ-006 SHALL have port Zero, input, 1 bit: the ALU Zero flag.
REQ-007 SHALL have port MemReady, input, 1 bit: memory completes the current access in this cycle.
REQ-008 SHALL have outputs PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, RegDst, MemToReg, RegWrite and AluSrcA, each 1 bit: datapath strobes and mux selects.
REQ-009 SHALL have outputs AluSrcB and PcSource, each 2 bits: mux selects.
REQ-010 SHALL have output AluCon, 4 bits: the ALU operation code.
REQ-011 SHALL have output Fault, 1 bit: sticky error flag.
REQ-012 SHALL have output State, 4 bits: the current state encoding, for debug.

Function
REQ-013 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB and FAULT.
REQ-014 SHALL use AluCon encodings AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111 and NOR=1100.
REQ-015 SHALL drive every output 0 unless listed for the state, except AluCon, which defaults to ADD.
REQ-016 FETCH SHALL drive MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, PcSource=00; IrWrite and PcWrite SHALL equal MemReady; go to DECODE when MemReady=1, else stay.
REQ-017 DECODE SHALL drive AluSrcA=0, AluSrcB=11 and dispatch on Opcode:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDIEX
- any other opcode -> FAULT
REQ-018 DECODE with Opcode=000000 and Funct outside {100000, 100010, 100100, 100101, 100111, 101010} SHALL go to FAULT.
REQ-019 MEMADR and ADDIEX SHALL drive AluSrcA=1, AluSrcB=10; MEMADR goes to MEMRD for lw and MEMWR for sw; ADDIEX goes to ADDIWB.
REQ-020 MEMRD SHALL drive MemRead=1, IorD=1 and go to MEMWB when MemReady=1.
REQ-021 MEMWR SHALL drive MemWrite=1, IorD=1 and go to FETCH when MemReady=1.
REQ-022 MEMWB SHALL drive RegWrite=1, MemToReg=1, RegDst=0; go to FETCH.
REQ-023 EXEC SHALL drive AluSrcA=1, AluSrcB=00 and AluCon decoded from Funct:
- 100000 -> ADD
- 100010 -> SUB
- 100100 -> AND
- 100101 -> OR
- 100111 -> NOR
- 101010 -> SLT
REQ-024 EXEC SHALL go to ALUWB.
REQ-025 ALUWB SHALL drive RegWrite=1, RegDst=1; go to FETCH.
REQ-026 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemToReg=0; go to FETCH.
REQ-027 BRANCH SHALL drive AluSrcA=1, AluSrcB=00, AluCon=SUB, PcWriteCond=1, PcSource=01; go to FETCH regardless of Zero.
REQ-028 JUMP SHALL drive PcWrite=1, PcSource=10; go to FETCH.
REQ-029 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle MemReady=0.
REQ-030 When the wait counter reaches WAIT_LIMIT with MemReady=0, the FSM SHALL go to FAULT; MemReady=1 in that same cycle SHALL win.
REQ-031 FAULT SHALL drive all strobes 0 and Fault=1, and SHALL be left only by reset.
REQ-032 Cycle counts with MemReady immediate SHALL be:
- R-type: 4
- lw: 5
- sw: 4
- beq: 3
- j: 3
- addi: 4
REQ-033 Outputs SHALL be combinational from the state register and MemReady only; no output SHALL depend on Opcode or Funct outside DECODE and EXEC.

Reset
REQ-034 Rst_n=0 SHALL immediately force state FETCH, clear the wait counter and clear Fault.
REQ-035 During reset all strobes SHALL be 0, MemRead and IrWrite SHALL be gated low, AluCon=ADD and State=FETCH.
REQ-036 Reset asserted mid-instruction SHALL abandon it with no further RegWrite, MemWrite or PcWrite.

Structure
REQ-037 Package mips_pkg SHALL hold the state enum, the AluCon encodings, and the opcode and funct constants.
REQ-038 Sub-module alu_con_decoder SHALL map Funct to AluCon and an illegal flag, purely combinational.

Verification
REQ-039 Reset with MemReady=0 -> State=FETCH, MemRead=0, Fault=0; after release, MemRead=1.
REQ-040 Opcode=000000, Funct=100010, MemReady=1 -> FETCH, DECODE, EXEC with AluCon=0110, ALUWB with RegWrite=1 and RegDst=1, then FETCH; 4 cycles.
REQ-041 lw (100011) with MemReady low 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB with MemToReg=1.
REQ-042 beq (000100), Zero=1 -> BRANCH with PcWriteCond=1, PcSource=01, AluCon=0110; 3 cycles total.
REQ-043 WAIT_LIMIT=3, MemReady=0 in FETCH -> FAULT entered 3 cycles after the wait starts; Fault stays 1 until Rst_n pulse.
REQ-044 Opcode=111111 -> FAULT directly after DECODE; Rst_n=0 during MEMWR -> FETCH with no MemWrite pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_con;
        logic       fault;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c         = '0;
        c.alu_con = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/alu_con_decoder.sv
// R-type funct field to ALU operation; flags funct codes the datapath cannot execute.
module alu_con_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_con,
    output logic       illegal
);

    always_comb begin
        alu_con = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_con = ALU_ADD;
            FN_SUB:  alu_con = ALU_SUB;
            FN_AND:  alu_con = ALU_AND;
            FN_OR:   alu_con = ALU_OR;
            FN_NOR:  alu_con = ALU_NOR;
            FN_SLT:  alu_con = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM with a bounded MemReady wait and a sticky fault state.
module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PcWrite,
    output logic       PcWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IrWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] PcSource,
    output logic [3:0] AluCon,
    output logic       Fault,
    output logic [3:0] State
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic          wait_state, at_limit;
    logic [3:0]    dec_alu_con;
    logic          dec_illegal;
    ctrl_t         ctrl;

    // Zero is consumed by the datapath through PcWriteCond, not by the FSM.
    logic unused_zero;
    assign unused_zero = Zero;

    alu_con_decoder u_dec (
        .funct   (Funct),
        .alu_con (dec_alu_con),
        .illegal (dec_illegal)
    );

    assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // Faulting cycle is the one that would make the count reach the limit.
    assign at_limit   = (wait_cnt == LAST_WAIT);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                        wait_cnt <= '0;
        else if (next_state != state)      wait_cnt <= '0;
        else if (wait_state && !MemReady)  wait_cnt <= wait_cnt + CW'(1);
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (MemReady) next_state = S_DECODE;
                      else if (at_limit) next_state = S_FAULT;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = dec_illegal ? S_FAULT : S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FAULT;
                endcase
            end
            S_MEMADR: next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) next_state = S_MEMWB;
                      else if (at_limit) next_state = S_FAULT;
            S_MEMWR:  if (MemReady) next_state = S_FETCH;
                      else if (at_limit) next_state = S_FAULT;
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_FAULT;
        endcase
    end

    // Reset gates every strobe, including the FETCH read the reset state would otherwise issue.
    always_comb begin
        ctrl = ctrl_idle();
        if (Rst_n) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = 2'b01;
                    ctrl.ir_write  = MemReady;
                    ctrl.pc_write  = MemReady;
                end
                S_DECODE: ctrl.alu_src_b = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.ior_d    = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.ior_d     = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_con   = dec_alu_con;
                end
                S_ALUWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_ADDIWB: ctrl.reg_write = 1'b1;
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_con       = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = 2'b01;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = 2'b10;
                end
                S_FAULT: ctrl.fault = 1'b1;
                default: ctrl.fault = 1'b1;
            endcase
        end
    end

    assign PcWrite     = ctrl.pc_write;
    assign PcWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.ior_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IrWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemToReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign AluSrcA     = ctrl.alu_src_a;
    assign AluSrcB     = ctrl.alu_src_b;
    assign PcSource    = ctrl.pc_source;
    assign AluCon      = ctrl.alu_con;
    assign Fault       = ctrl.fault;
    assign State       = state;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Scoreboarded bench for mips_ctrl_fsm: per-cycle expected state and control vector.
module tb_mips_ctrl_fsm;
    import mips_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [5:0] Opcode = '0;
    logic [5:0] Funct = '0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite;
    logic       RegDst, MemToReg, RegWrite, AluSrcA, Fault;
    logic [1:0] AluSrcB, PcSource;
    logic [3:0] AluCon, State;

    int checks = 0;
    int errors = 0;

    mips_ctrl_fsm #(.WAIT_LIMIT(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IrWrite(IrWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .PcSource(PcSource), .AluCon(AluCon), .Fault(Fault), .State(State)
    );

    always #5 Clk = ~Clk;

    logic [18:0] obs;
    assign obs = {PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, RegDst, MemToReg,
                  RegWrite, AluSrcA, AluSrcB, PcSource, AluCon, Fault};

    localparam logic [18:0] RST_EXP = {14'b0, 4'b0010, 1'b0};

    typedef struct {
        logic        mr;
        logic [3:0]  st;
        logic [18:0] ctl;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // Expected control vector from the per-state output table.
    function automatic logic [18:0] model(state_t st, logic mr, logic [3:0] ac);
        logic pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, asa, flt;
        logic [1:0] asb, pcs;
        logic [3:0] alu;
        {pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, asa, flt} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 4'b0010;
        case (st)
            S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            S_DECODE: asb = 2'b11;
            S_MEMADR, S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iord = 1; end
            S_MEMWR:  begin mwr = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_EXEC:   begin asa = 1; alu = ac; end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_ADDIWB: rw = 1;
            S_BRANCH: begin asa = 1; alu = 4'b0110; pwc = 1; pcs = 2'b01; end
            S_JUMP:   begin pw = 1; pcs = 2'b10; end
            default:  flt = 1;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, asa, asb, pcs, alu, flt};
    endfunction

    function automatic void push(logic mr, state_t st, logic [3:0] ac = 4'b0010);
        exp_t x;
        x.mr = mr; x.st = st; x.ctl = model(st, mr, ac);
        sb.push_back(x);
    endfunction

    // Leaves the bench just after release, inside the first FETCH cycle.
    task automatic apply_reset();
        MemReady = 1'b0;
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; MemReady = 1'b0;
        #3;
        checks++;
        if (State !== 4'(S_FETCH) || obs !== RST_EXP) begin
            errors++; $display("FAIL reset_idle state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, S_FETCH, RST_EXP);
        end
        MemReady = 1'b1; #2;
        checks++;
        if (obs !== RST_EXP) begin
            errors++; $display("FAIL reset_gate ctl=%b exp %b", obs, RST_EXP);
        end
        @(posedge Clk); #1;
        checks++;
        if (State !== 4'(S_FETCH) || obs !== RST_EXP) begin
            errors++; $display("FAIL reset_hold state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, S_FETCH, RST_EXP);
        end
        MemReady = 1'b0;
        @(negedge Clk); Rst_n = 1'b1; #1;
        checks++;
        if (State !== 4'(S_FETCH) || obs !== model(S_FETCH, 1'b0, 4'b0010)) begin
            errors++; $display("FAIL reset_release state=%0d ctl=%b exp ctl=%b", State, obs, model(S_FETCH, 1'b0, 4'b0010));
        end
    endtask

    task automatic test_rtype_sub();
        apply_reset();
        Opcode = OP_RTYPE; Funct = 6'b100010;
        push(1, S_FETCH); push(1, S_DECODE); push(1, S_EXEC, 4'b0110); push(1, S_ALUWB); push(0, S_FETCH);
        while (sb.size() > 0) begin
            e = sb.pop_front(); MemReady = e.mr; #2;
            checks++;
            if (State !== e.st || obs !== e.ctl) begin
                errors++; $display("FAIL rtype_sub state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, e.st, e.ctl);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_alu_funct();
        logic [5:0] fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        logic [3:0] ac [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            Opcode = OP_RTYPE; Funct = fn[i];
            push(1, S_FETCH); push(1, S_DECODE); push(0, S_EXEC, ac[i]); push(0, S_ALUWB);
            while (sb.size() > 0) begin
                e = sb.pop_front(); MemReady = e.mr; #2;
                checks++;
                if (State !== e.st || obs !== e.ctl) begin
                    errors++; $display("FAIL alu_funct[%0d] state=%0d ctl=%b exp state=%0d ctl=%b", i, State, obs, e.st, e.ctl);
                end
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic test_lw_wait();
        apply_reset();
        Opcode = OP_LW;
        push(1, S_FETCH); push(1, S_DECODE); push(1, S_MEMADR);
        push(0, S_MEMRD); push(0, S_MEMRD); push(1, S_MEMRD); push(0, S_MEMWB); push(0, S_FETCH);
        while (sb.size() > 0) begin
            e = sb.pop_front(); MemReady = e.mr; #2;
            checks++;
            if (State !== e.st || obs !== e.ctl) begin
                errors++; $display("FAIL lw_wait state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, e.st, e.ctl);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_other_ops();
        for (int k = 0; k < 5; k++) begin
            apply_reset();
            push(1, S_FETCH); push(1, S_DECODE);
            case (k)
                0: begin Opcode = OP_BEQ; Zero = 1'b1; push(1, S_BRANCH); end
                1: begin Opcode = OP_BEQ; Zero = 1'b0; push(1, S_BRANCH); end
                2: begin Opcode = OP_J; push(1, S_JUMP); end
                3: begin Opcode = OP_ADDI; push(1, S_ADDIEX); push(1, S_ADDIWB); end
                default: begin Opcode = OP_SW; push(1, S_MEMADR); push(1, S_MEMWR); end
            endcase
            push(0, S_FETCH);
            while (sb.size() > 0) begin
                e = sb.pop_front(); MemReady = e.mr; #2;
                checks++;
                if (State !== e.st || obs !== e.ctl) begin
                    errors++; $display("FAIL other_ops[%0d] state=%0d ctl=%b exp state=%0d ctl=%b", k, State, obs, e.st, e.ctl);
                end
                @(posedge Clk); #1;
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            if (k == 0) begin Opcode = 6'b111111; Funct = 6'b100000; end
            else        begin Opcode = OP_RTYPE;  Funct = 6'b000000; end
            push(1, S_FETCH); push(1, S_DECODE); push(1, S_FAULT); push(0, S_FAULT); push(1, S_FAULT);
            while (sb.size() > 0) begin
                e = sb.pop_front(); MemReady = e.mr; #2;
                checks++;
                if (State !== e.st || obs !== e.ctl) begin
                    errors++; $display("FAIL illegal[%0d] state=%0d ctl=%b exp state=%0d ctl=%b", k, State, obs, e.st, e.ctl);
                end
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic test_wait_fault();
        apply_reset();
        Opcode = OP_J;
        push(0, S_FETCH); push(0, S_FETCH); push(0, S_FETCH);
        push(0, S_FAULT); push(1, S_FAULT); push(1, S_FAULT);
        while (sb.size() > 0) begin
            e = sb.pop_front(); MemReady = e.mr; #2;
            checks++;
            if (State !== e.st || obs !== e.ctl) begin
                errors++; $display("FAIL wait_fault state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, e.st, e.ctl);
            end
            @(posedge Clk); #1;
        end
        Rst_n = 1'b0; MemReady = 1'b0; #1;
        checks++;
        if (State !== 4'(S_FETCH) || Fault !== 1'b0) begin
            errors++; $display("FAIL fault_clear state=%0d fault=%b exp state=%0d fault=0", State, Fault, S_FETCH);
        end
        @(negedge Clk); Rst_n = 1'b1;
    endtask

    task automatic test_wait_boundary();
        apply_reset();
        Opcode = OP_SW;
        push(0, S_FETCH); push(0, S_FETCH); push(1, S_FETCH); push(1, S_DECODE); push(1, S_MEMADR);
        push(0, S_MEMWR); push(0, S_MEMWR); push(1, S_MEMWR); push(0, S_FETCH);
        while (sb.size() > 0) begin
            e = sb.pop_front(); MemReady = e.mr; #2;
            checks++;
            if (State !== e.st || obs !== e.ctl) begin
                errors++; $display("FAIL wait_boundary state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, e.st, e.ctl);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset_mid_memwr();
        apply_reset();
        Opcode = OP_SW;
        push(1, S_FETCH); push(1, S_DECODE); push(1, S_MEMADR); push(0, S_MEMWR);
        while (sb.size() > 0) begin
            e = sb.pop_front(); MemReady = e.mr; #2;
            checks++;
            if (State !== e.st || obs !== e.ctl) begin
                errors++; $display("FAIL mid_reset_pre state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, e.st, e.ctl);
            end
            @(posedge Clk); #1;
        end
        Rst_n = 1'b0; MemReady = 1'b1; #1;
        checks++;
        if (State !== 4'(S_FETCH) || obs !== RST_EXP) begin
            errors++; $display("FAIL mid_reset_abort state=%0d ctl=%b exp state=%0d ctl=%b", State, obs, S_FETCH, RST_EXP);
        end
        @(posedge Clk); #1;
        checks++;
        if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || PcWrite !== 1'b0 || State !== 4'(S_FETCH)) begin
            errors++; $display("FAIL mid_reset_hold state=%0d memwrite=%b regwrite=%b pcwrite=%b exp FETCH/0/0/0", State, MemWrite, RegWrite, PcWrite);
        end
        MemReady = 1'b0;
        @(negedge Clk); Rst_n = 1'b1; #1;
        checks++;
        if (State !== 4'(S_FETCH) || obs !== model(S_FETCH, 1'b0, 4'b0010)) begin
            errors++; $display("FAIL mid_reset_release state=%0d ctl=%b exp ctl=%b", State, obs, model(S_FETCH, 1'b0, 4'b0010));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype_sub();
        test_alu_funct();
        test_lw_wait();
        test_other_ops();
        test_illegal();
        test_wait_fault();
        test_wait_boundary();
        test_reset_mid_memwr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
